// File: rtl/spi_byte_master_if.sv
// Byte handshake and SPI pad bundle for spi_byte_master.
// master: the engine's view (drives the handshake status and the SPI pads).
// slave:  the peer's view (the I2C front end supplying bytes, plus the MISO pad).
interface spi_byte_master_if;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       busy_o;
   logic       sck_o;
   logic       mosi_o;
   logic       miso_i;
   logic       ss_n_o;

   modport master (
      input  tx_data_i, tx_valid_i, miso_i,
      output tx_ready_o, rx_data_o, rx_valid_o, busy_o, sck_o, mosi_o, ss_n_o
   );

   modport slave (
      output tx_data_i, tx_valid_i, miso_i,
      input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, sck_o, mosi_o, ss_n_o
   );
endinterface

// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-level SPI master. Accepts a byte over a valid/ready
// handshake, shifts it out on MOSI while capturing MISO, then presents the
// received byte with a one-cycle valid pulse. All pad outputs are registered.
// Optional build macro SPI_LSB_FIRST_EN: shift LSB first (default MSB first).
module spi_byte_master #(
   parameter int unsigned CLK_DIV = 4,    // system clocks per SCK half-period, 1..255
   parameter bit          CPOL    = 1'b0, // SCK idle level
   parameter bit          CPHA    = 1'b0  // 0: sample leading edge, 1: sample trailing edge
) (
   input  logic               i2c_wb_clk_i,
   input  logic               i2c_wb_rst_i,
   spi_byte_master_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_TAIL,
      ST_DONE
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_e     state_q,    state_d;
   logic [7:0] div_cnt_q,  div_cnt_d;
   logic [3:0] bit_cnt_q,  bit_cnt_d;
   logic [7:0] tx_sr_q,    tx_sr_d;
   logic [7:0] rx_sr_q,    rx_sr_d;
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       sck_q,      sck_d;
   logic       mosi_q,     mosi_d;
   logic       ss_n_q,     ss_n_d;

   logic tick;
   logic last_tick;
   logic sample_edge;

`ifdef SPI_LSB_FIRST_EN
   function automatic logic first_bit(input logic [7:0] d);
      return d[0];
   endfunction

   function automatic logic [7:0] tx_shift(input logic [7:0] d);
      return {1'b0, d[7:1]};
   endfunction

   function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic b);
      return {b, d[7:1]};
   endfunction
`else
   function automatic logic first_bit(input logic [7:0] d);
      return d[7];
   endfunction

   function automatic logic [7:0] tx_shift(input logic [7:0] d);
      return {d[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic b);
      return {d[6:0], b};
   endfunction
`endif

   // Divider tick and SCK edge classification; bit_cnt_q counts ticks 0..15,
   // so an even count is the upcoming leading (odd-numbered) edge.
   assign tick        = (div_cnt_q == DIV_LAST);
   assign last_tick   = (bit_cnt_q == 4'd15);
   assign sample_edge = (~bit_cnt_q[0]) ^ CPHA;

   // Next-state and registered-output logic for the transfer sequence.
   always_comb begin
      // NOTE: every variable gets a default here first, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      ss_n_d     = ss_n_q;

      unique case (state_q)
         ST_IDLE: begin
            div_cnt_d = 8'd0;
            if (bus.tx_valid_i) begin
               state_d   = ST_LEAD;
               ss_n_d    = 1'b0;
               bit_cnt_d = 4'd0;
               rx_sr_d   = 8'd0;
               if (!CPHA) begin
                  // Mode with leading-edge sampling: first bit must be on the
                  // pad before the first SCK edge.
                  mosi_d  = first_bit(bus.tx_data_i);
                  tx_sr_d = tx_shift(bus.tx_data_i);
               end else begin
                  tx_sr_d = bus.tx_data_i;
               end
            end
         end

         ST_LEAD: begin
            if (tick) begin
               state_d   = ST_SHIFT;
               div_cnt_d = 8'd0;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               div_cnt_d = 8'd0;
               sck_d     = ~sck_q;
               if (sample_edge) begin
                  rx_sr_d = rx_shift(rx_sr_q, bus.miso_i);
               end else if (!last_tick) begin
                  mosi_d  = first_bit(tx_sr_q);
                  tx_sr_d = tx_shift(tx_sr_q);
               end
               if (last_tick) begin
                  sck_d   = CPOL;
                  state_d = ST_TAIL;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_TAIL: begin
            if (tick) begin
               state_d    = ST_DONE;
               div_cnt_d  = 8'd0;
               ss_n_d     = 1'b1;
               rx_data_d  = rx_sr_q;
               rx_valid_d = 1'b1;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_DONE: begin
            state_d   = ST_IDLE;
            div_cnt_d = 8'd0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset; reset aborts any
   // transfer in flight and discards the partial byte.
   always_ff @(posedge i2c_wb_clk_i) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (i2c_wb_rst_i) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= 8'd0;
         bit_cnt_q  <= 4'd0;
         tx_sr_q    <= 8'd0;
         rx_sr_q    <= 8'd0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         sck_q      <= CPOL;
         mosi_q     <= 1'b0;
         ss_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
      end
   end

   assign bus.tx_ready_o = (state_q == ST_IDLE);
   assign bus.busy_o     = (state_q != ST_IDLE);
   assign bus.rx_data_o  = rx_data_q;
   assign bus.rx_valid_o = rx_valid_q;
   assign bus.sck_o      = sck_q;
   assign bus.mosi_o     = mosi_q;
   assign bus.ss_n_o     = ss_n_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: three instances in different SPI modes and
// dividers, each with a behavioural SPI slave or a MISO-to-MOSI loopback.
module tb_spi_byte_master;

   localparam int NI = 3;
   localparam int DIV_P  [NI] = '{4, 2, 1};
   localparam bit CPOL_P [NI] = '{1'b0, 1'b1, 1'b0};
   localparam bit CPHA_P [NI] = '{1'b0, 1'b1, 1'b1};

   logic clk = 1'b0;
   logic rst;

   logic [7:0] tx_data  [NI];
   logic       tx_valid [NI];
   logic       lb       [NI];
   logic [7:0] s_tx     [NI];

   logic       tx_ready [NI];
   logic [7:0] rx_data  [NI];
   logic       rx_valid [NI];
   logic       busy     [NI];
   logic       sck      [NI];
   logic       mosi     [NI];
   logic       ss_n     [NI];
   logic [7:0] s_rx     [NI];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Position within the byte of the k-th bit on the wire.
   function automatic int bpos(input int k);
`ifdef SPI_LSB_FIRST_EN
      return k;
`else
      return 7 - k;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam bit CPOL_G = CPOL_P[g];
      localparam bit CPHA_G = CPHA_P[g];

      spi_byte_master_if bus ();

      logic       miso_s = 1'b0;
      logic [7:0] s_rx_q = 8'd0;

      assign bus.tx_data_i  = tx_data[g];
      assign bus.tx_valid_i = tx_valid[g];
      assign bus.miso_i     = lb[g] ? bus.mosi_o : miso_s;
      assign tx_ready[g]    = bus.tx_ready_o;
      assign rx_data[g]     = bus.rx_data_o;
      assign rx_valid[g]    = bus.rx_valid_o;
      assign busy[g]        = bus.busy_o;
      assign sck[g]         = bus.sck_o;
      assign mosi[g]        = bus.mosi_o;
      assign ss_n[g]        = bus.ss_n_o;
      assign s_rx[g]        = s_rx_q;

      spi_byte_master #(
         .CLK_DIV (DIV_P[g]),
         .CPOL    (CPOL_G),
         .CPHA    (CPHA_G)
      ) u_dut (
         .i2c_wb_clk_i (clk),
         .i2c_wb_rst_i (rst),
         .bus          (bus.master)
      );

      // Behavioural SPI slave: samples MOSI on its sample edge, drives MISO
      // on the opposite edge (first bit at select for CPHA=0).
      logic       prev_ss  = 1'b1;
      logic       prev_sck = CPOL_G;
      logic [7:0] rxb      = 8'd0;
      int         ns = 0;
      int         nc = 0;
      always @(bus.ss_n_o or bus.sck_o) begin
         if (bus.ss_n_o === 1'b0 && prev_ss === 1'b1) begin
            ns  = 0;
            nc  = 0;
            rxb = 8'd0;
            if (!CPHA_G) begin
               miso_s <= s_tx[g][bpos(0)];
               nc = 1;
            end
         end else if (bus.ss_n_o === 1'b0 && bus.sck_o !== prev_sck) begin
            if ((bus.sck_o != CPOL_G) == !CPHA_G) begin
               if (ns < 8) begin
                  rxb[bpos(ns)] = bus.mosi_o;
                  ns++;
                  if (ns == 8) s_rx_q <= rxb;
               end
            end else if (nc < 8) begin
               miso_s <= s_tx[g][bpos(nc)];
               nc++;
            end
         end
         prev_ss  = bus.ss_n_o;
         prev_sck = bus.sck_o;
      end
   end

   // One transfer on instance i; junk=1 wiggles tx_valid/tx_data while busy.
   task automatic xfer(input int i, input logic [7:0] tx, input logic [7:0] sb,
                       input bit loop_en, input bit junk);
      int d, c, lat, ss_low, rises;
      logic prev;
      logic [7:0] exp_rx;
      d = DIV_P[i];
      exp_rx = loop_en ? tx : sb;
      @(negedge clk);
      lb[i] = loop_en;
      s_tx[i] = sb;
      tx_data[i] = tx;
      tx_valid[i] = 1'b1;
      check($sformatf("idle_ready[%0d]", i), tx_ready[i], 1);
      check($sformatf("idle_sck[%0d]", i), sck[i], CPOL_P[i]);
      prev = sck[i];
      @(posedge clk);
      c = 0; lat = 0; ss_low = 0; rises = 0;
      while (c < 18 * d + 40 && lat == 0) begin
         @(negedge clk);
         c++;
         if (junk && c <= 18 * d) begin
            tx_valid[i] = 1'($urandom_range(0, 1));
            tx_data[i]  = 8'($urandom);
         end else begin
            tx_valid[i] = 1'b0;
         end
         if (c == 1) begin
            check($sformatf("busy[%0d]", i), busy[i], 1);
            check($sformatf("ready_busy[%0d]", i), tx_ready[i], 0);
            if (!CPHA_P[i]) check($sformatf("mosi_first[%0d]", i), mosi[i], tx[bpos(0)]);
         end
         if (ss_n[i] == 1'b0) ss_low++;
         if (sck[i] && !prev) rises++;
         prev = sck[i];
         if (rx_valid[i]) lat = c;
      end
      tx_valid[i] = 1'b0;
      check($sformatf("latency[%0d]", i), lat, 18 * d + 1);
      check($sformatf("rx_data[%0d]", i), rx_data[i], exp_rx);
      check($sformatf("ss_low[%0d]", i), ss_low, 18 * d);
      check($sformatf("sck_rises[%0d]", i), rises, 8);
      check($sformatf("slave_rx[%0d]", i), s_rx[i], tx);
      @(negedge clk);
      check($sformatf("rx_valid_pulse[%0d]", i), rx_valid[i], 0);
      check($sformatf("rx_hold[%0d]", i), rx_data[i], exp_rx);
      check($sformatf("ss_end[%0d]", i), ss_n[i], 1);
      check($sformatf("busy_end[%0d]", i), busy[i], 0);
   endtask

   // tx_valid held high across two bytes in loopback.
   task automatic b2b(input int i);
      int d, c, lat1, lat2, acc2, hi;
      d = DIV_P[i];
      @(negedge clk);
      lb[i] = 1'b1;
      tx_data[i] = 8'h01;
      tx_valid[i] = 1'b1;
      @(posedge clk);
      c = 0; lat1 = 0; lat2 = 0; acc2 = 0; hi = 0;
      while (c < 36 * d + 60 && lat2 == 0) begin
         @(negedge clk);
         c++;
         if (c == 1) tx_data[i] = 8'h02;
         if (acc2 != 0 && c == acc2 + 1) tx_valid[i] = 1'b0;
         if (rx_valid[i]) begin
            if (lat1 == 0) begin
               lat1 = c;
               check("b2b_rx1", rx_data[i], 8'h01);
            end else begin
               lat2 = c;
               check("b2b_rx2", rx_data[i], 8'h02);
            end
         end
         if (lat1 != 0 && lat2 == 0 && ss_n[i]) hi++;
         if (lat1 != 0 && acc2 == 0 && tx_ready[i] && tx_valid[i]) acc2 = c;
      end
      tx_valid[i] = 1'b0;
      check("b2b_lat1", lat1, 18 * d + 1);
      check("b2b_accept2", acc2, lat1 + 1);
      check("b2b_ss_high", hi, 2);
      check("b2b_lat2", lat2, acc2 + 18 * d + 1);
   endtask

   // One-cycle reset during bit 4 of a transfer, then a clean transfer.
   task automatic reset_mid(input int i);
      int d, c, pulses;
      d = DIV_P[i];
      @(negedge clk);
      lb[i] = 1'b1;
      tx_data[i] = 8'h5A;
      tx_valid[i] = 1'b1;
      @(posedge clk);
      c = 0;
      while (c < 9 * d + 2) begin
         @(negedge clk);
         c++;
         tx_valid[i] = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_ss_n", ss_n[i], 1);
      check("rst_sck", sck[i], CPOL_P[i]);
      check("rst_busy", busy[i], 0);
      check("rst_rx_valid", rx_valid[i], 0);
      check("rst_rx_data", rx_data[i], 0);
      pulses = 0;
      repeat (18 * d + 10) begin
         @(negedge clk);
         if (rx_valid[i]) pulses++;
      end
      check("rst_no_pulse", pulses, 0);
      xfer(i, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         tx_data[i]  = 8'd0;
         tx_valid[i] = 1'b0;
         lb[i]       = 1'b1;
         s_tx[i]     = 8'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_sck[%0d]", i), sck[i], CPOL_P[i]);
         check($sformatf("reset_ss_n[%0d]", i), ss_n[i], 1);
         check($sformatf("reset_mosi[%0d]", i), mosi[i], 0);
         check($sformatf("reset_busy[%0d]", i), busy[i], 0);
         check($sformatf("reset_rx_valid[%0d]", i), rx_valid[i], 0);
         check($sformatf("reset_rx_data[%0d]", i), rx_data[i], 0);
         check($sformatf("reset_ready[%0d]", i), tx_ready[i], 1);
      end
      rst = 1'b0;

      xfer(0, 8'hA5, 8'h00, 1'b1, 1'b0);
      xfer(1, 8'hF0, 8'h3C, 1'b0, 1'b0);
      xfer(2, 8'h81, 8'h00, 1'b1, 1'b0);
      xfer(0, 8'h01, 8'h00, 1'b1, 1'b0);
      b2b(2);
      b2b(1);
      reset_mid(0);

      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NI; i++) begin
            xfer(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
